spi_mem_ctrl: RTL and testbench
===============================

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter AUTO_INC, default 1, meaning 1 = post-increment wr_addr/rd_addr after each completed data access, 0 = hold.
REQ-002 Parameter TIMEOUT, default 16, meaning max cycles mem_req waits for mem_ack before abort; legal range 2..255.
REQ-003 The block SHALL use clock clk and reset rst_n; rst_n is asynchronous and active-low.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rx_data  in  10  command word: [9:8] opcode, [7:0] payload.
REQ-007 rx_valid  in  1  rx_data valid, level; one rising edge = one command.
REQ-008 tx_data  out  8  read data for the serializer.
REQ-009 tx_valid  out  1  tx_data valid.
REQ-010 mem_req  out  1  memory request, held until acknowledged.
REQ-011 mem_we  out  1  1 = write, 0 = read.
REQ-012 mem_addr  out  8  memory address.
REQ-013 mem_wdata  out  8  memory write data.
REQ-014 mem_rdata  in  8  memory read data, valid with mem_ack.
REQ-015 mem_ack  in  1  memory acknowledge, one cycle.
REQ-016 busy  out  1  memory transaction in progress.
REQ-017 err  out  1  one-cycle error pulse.

Function
REQ-018 Opcodes SHALL be: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-019 A command SHALL be accepted on the cycle where rx_valid=1, registered rx_valid_q=0 and state=IDLE; a held-high rx_valid is one command.
REQ-020 States SHALL be IDLE, WRITE, READ; busy SHALL equal (state != IDLE).
REQ-021 Any accepted command SHALL clear tx_valid on the accepting edge.
REQ-022 WR_ADDR SHALL load wr_addr<=payload; RD_ADDR SHALL load rd_addr<=payload and set rd_addr_vld; both stay IDLE with no memory activity.
REQ-023 WR_DATA SHALL enter WRITE with mem_req=1, mem_we=1, mem_addr=wr_addr, mem_wdata=payload from the next cycle.
REQ-024 RD_DATA with rd_addr_vld=1 SHALL enter READ with mem_req=1, mem_we=0, mem_addr=rd_addr from the next cycle; payload ignored.
REQ-025 RD_DATA with rd_addr_vld=0 SHALL pulse err for one cycle, stay IDLE, issue no request.
REQ-026 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable until mem_ack is sampled high, then return to 0 on the following cycle with state IDLE.
REQ-027 Latency: accept at cycle N -> mem_req high at N+1; mem_ack at cycle M -> mem_req low and (READ) tx_valid high at M+1; ack at N+1 gives a one-cycle request.
REQ-028 READ completion SHALL capture tx_data<=mem_rdata; tx_data and tx_valid SHALL hold until the next accepted command.
REQ-029 On completion the used address SHALL increment by AUTO_INC, modulo 256 (8'hFF -> 8'h00).
REQ-030 A cycle counter SHALL count mem_req-high cycles; if TIMEOUT cycles elapse without mem_ack: mem_req low next cycle, IDLE, err pulse, no address increment, tx_valid stays 0.
REQ-031 mem_ack on the TIMEOUT-th cycle SHALL count as completion, not timeout.
REQ-032 An rx_valid rising edge while busy SHALL be dropped with one err pulse; addresses unchanged.
REQ-033 Coincident drop and timeout errors SHALL produce a single err pulse.
REQ-034 mem_ack while IDLE SHALL be ignored.

Reset
REQ-035 Assertion of rst_n SHALL immediately force all outputs to 0, state IDLE, wr_addr=rd_addr=0, rd_addr_vld=0, counter 0, aborting any transaction.
REQ-036 rx_valid_q SHALL reset to 1 so rx_valid high at reset release is not a command.

Structure
REQ-037 Package spi_mem_pkg SHALL hold opcode constants, state encoding, CMD_W=10, PAYLOAD_W=8.
REQ-038 The timeout counter SHALL be sub-module spi_mem_timeout (load, count, expire); everything else in spi_mem_ctrl.

Verification
REQ-039 rx 10'h005 then 10'h1A5, ack after 3 cycles -> mem_req 3 cycles, we=1, addr 8'h05, wdata 8'hA5; wr_addr becomes 8'h06.
REQ-040 rx 10'h205 then 10'h300, mem_rdata 8'hA5 ack after 2 cycles -> tx_data 8'hA5, tx_valid 1 held until next command; rd_addr 8'h06.
REQ-041 After reset rx 10'h300 -> err one cycle, mem_req never asserted.
REQ-042 rx 10'h0FF then two WR_DATA -> mem_addr 8'hFF then 8'h00.
REQ-043 TIMEOUT=16, mem_ack held 0 -> mem_req exactly 16 cycles, one err pulse, busy low, next command accepted.
REQ-044 rx_valid edge during WRITE -> err pulse, command dropped; rst_n low mid-READ -> mem_req and tx_valid 0 immediately.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI memory controller: command format, opcodes, state encoding.
package spi_mem_pkg;

  localparam int CMD_W     = 10;
  localparam int PAYLOAD_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

endpackage

// File: rtl/spi_mem_timeout.sv
// Request watchdog: down-counter loaded at request start, decremented while the request is open.
module spi_mem_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(TIMEOUT);
    end else if (count && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Count holds TIMEOUT on the first request cycle, so 1 marks the last allowed cycle.
  assign expire = count && (cnt == 8'd1);

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command decoder bridging SPI command words to a single-outstanding memory request port.
//   state    | meaning
//   ST_IDLE  | waiting for a command edge
//   ST_WRITE | write request open, waiting for mem_ack
//   ST_READ  | read request open, waiting for mem_ack
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_W-1:0]     rx_data,
  input  logic                 rx_valid,
  output logic [PAYLOAD_W-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [7:0]           mem_addr,
  output logic [PAYLOAD_W-1:0] mem_wdata,
  input  logic [PAYLOAD_W-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 err
);

  logic [1:0]           state;
  logic                 rx_valid_q;
  logic [7:0]           wr_addr;
  logic [7:0]           rd_addr;
  logic                 rd_addr_vld;
  logic [1:0]           opcode;
  logic [PAYLOAD_W-1:0] payload;
  logic                 rx_rise;
  logic                 accept;
  logic                 drop;
  logic                 start_wr;
  logic                 start_rd;
  logic                 rd_err;
  logic                 done;
  logic                 expire;
  logic                 timeout;
  logic [7:0]           inc;

  assign opcode   = rx_data[9:8];
  assign payload  = rx_data[7:0];
  assign busy     = (state != ST_IDLE);
  assign inc      = (AUTO_INC != 0) ? 8'd1 : 8'd0;

  assign rx_rise  = rx_valid && !rx_valid_q;
  assign accept   = rx_rise && !busy;
  assign drop     = rx_rise && busy;
  assign start_wr = accept && (opcode == OP_WR_DATA);
  assign start_rd = accept && (opcode == OP_RD_DATA) && rd_addr_vld;
  assign rd_err   = accept && (opcode == OP_RD_DATA) && !rd_addr_vld;
  // An ack on the final allowed cycle wins over the watchdog.
  assign done     = busy && mem_ack;
  assign timeout  = busy && !mem_ack && expire;

  spi_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_wr || start_rd),
    .count  (busy),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rx_valid_q  <= 1'b1;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err         <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      err        <= rd_err || drop || timeout;
      if (accept) begin
        tx_valid <= 1'b0;
        case (opcode)
          OP_WR_ADDR: wr_addr <= payload;
          OP_RD_ADDR: begin
            rd_addr     <= payload;
            rd_addr_vld <= 1'b1;
          end
          OP_WR_DATA: begin
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= payload;
          end
          OP_RD_DATA: begin
            if (rd_addr_vld) begin
              state     <= ST_READ;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= rd_addr;
              mem_wdata <= '0;
            end
          end
          default: ;
        endcase
      end else if (done || timeout) begin
        state     <= ST_IDLE;
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        if (done) begin
          if (state == ST_READ) begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
            rd_addr  <= rd_addr + inc;
          end else begin
            wr_addr <= wr_addr + inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a transaction-level reference model checked every cycle.
module tb_spi_mem_ctrl;

  localparam int TIMEOUT  = 16;
  localparam int AUTO_INC = 1;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  spi_mem_ctrl #(.AUTO_INC(AUTO_INC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one request in flight, age = how many request cycles have been seen.
  bit m_prev_rx  = 1'b1;
  bit m_req      = 1'b0;
  bit m_is_read  = 1'b0;
  bit m_we       = 1'b0;
  int m_addr     = 0;
  int m_wdata    = 0;
  int m_tx_data  = 0;
  bit m_tx_valid = 1'b0;
  bit m_err      = 1'b0;
  int m_wr_addr  = 0;
  int m_rd_addr  = 0;
  bit m_rd_vld   = 1'b0;
  int m_age      = 0;
  bit rise;
  bit nerr;
  int op;
  int pl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_rx = 1'b1; m_req = 1'b0; m_is_read = 1'b0; m_we = 1'b0;
      m_addr = 0; m_wdata = 0; m_tx_data = 0; m_tx_valid = 1'b0; m_err = 1'b0;
      m_wr_addr = 0; m_rd_addr = 0; m_rd_vld = 1'b0; m_age = 0;
    end else begin
      rise = rx_valid && !m_prev_rx;
      m_prev_rx = rx_valid;
      nerr = 1'b0;
      if (m_req) begin
        if (mem_ack) begin
          if (m_is_read) begin
            m_tx_data  = int'(mem_rdata);
            m_tx_valid = 1'b1;
            m_rd_addr  = (m_rd_addr + AUTO_INC) % 256;
          end else begin
            m_wr_addr = (m_wr_addr + AUTO_INC) % 256;
          end
          m_req = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = 0;
        end else if (m_age == TIMEOUT) begin
          nerr = 1'b1;
          m_req = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = 0;
        end else begin
          m_age++;
        end
        if (rise) nerr = 1'b1;
      end else if (rise) begin
        m_tx_valid = 1'b0;
        op = int'(rx_data[9:8]);
        pl = int'(rx_data[7:0]);
        if (op == 0) begin
          m_wr_addr = pl;
        end else if (op == 2) begin
          m_rd_addr = pl;
          m_rd_vld  = 1'b1;
        end else if (op == 1) begin
          m_req = 1'b1; m_is_read = 1'b0; m_we = 1'b1;
          m_addr = m_wr_addr; m_wdata = pl; m_age = 1;
        end else if (m_rd_vld) begin
          m_req = 1'b1; m_is_read = 1'b1; m_we = 1'b0;
          m_addr = m_rd_addr; m_wdata = 0; m_age = 1;
        end else begin
          nerr = 1'b1;
        end
      end
      m_err = nerr;
    end
  end

  always @(negedge clk) begin
    check("tx_valid",  32'(tx_valid),  32'(m_tx_valid));
    check("tx_data",   32'(tx_data),   32'(m_tx_data));
    check("mem_req",   32'(mem_req),   32'(m_req));
    check("mem_we",    32'(mem_we),    32'(m_we));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("busy",      32'(busy),      32'(m_req));
    check("err",       32'(err),       32'(m_err));
  end

  // Observation counters for the hand-computed expectations.
  int         req_cycles = 0;
  int         err_cycles = 0;
  logic [7:0] last_addr  = '0;
  logic [7:0] last_wdata = '0;
  logic       last_we    = 1'b0;

  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_we    = mem_we;
    end
    if (err) err_cycles++;
  end

  task automatic clear_mon();
    req_cycles = 0;
    err_cycles = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Caller guarantees rx_valid was low at the previous edge.
  task automatic send(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic ack_on(input int k, input logic [7:0] d);
    repeat (k - 1) step();
    mem_ack   = 1'b1;
    mem_rdata = d;
    step();
    mem_ack   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      step();
      k++;
    end
    check("idle_within_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; rx_valid = 1'b1; rx_data = 10'h300;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

    clear_mon();
    idle(3);
    rx_valid = 1'b0;
    idle(1);
    check("held_rx_at_release_err", 32'(err_cycles), 32'd0);

    clear_mon();
    send(10'h300);
    idle(3);
    check("rd_no_addr_err", 32'(err_cycles), 32'd1);
    check("rd_no_addr_req", 32'(req_cycles), 32'd0);

    send(10'h005);
    idle(1);
    clear_mon();
    send(10'h1A5);
    ack_on(3, 8'h00);
    idle(2);
    check("wr_req_cycles", 32'(req_cycles), 32'd3);
    check("wr_addr",       32'(last_addr),  32'h05);
    check("wr_wdata",      32'(last_wdata), 32'hA5);
    check("wr_we",         32'(last_we),    32'd1);
    clear_mon();
    send(10'h1B0);
    ack_on(1, 8'h00);
    idle(1);
    check("wr_addr_inc", 32'(last_addr),  32'h06);
    check("wr_one_cycle", 32'(req_cycles), 32'd1);

    send(10'h205);
    idle(1);
    clear_mon();
    send(10'h300);
    ack_on(2, 8'hA5);
    idle(4);
    check("rd_tx_data",  32'(tx_data),   32'hA5);
    check("rd_tx_valid", 32'(tx_valid),  32'd1);
    check("rd_addr",     32'(last_addr), 32'h05);
    check("rd_we",       32'(last_we),   32'd0);
    send(10'h300);
    check("tx_valid_clr_on_accept", 32'(tx_valid), 32'd0);
    ack_on(1, 8'h3C);
    idle(1);
    check("rd_addr_inc", 32'(last_addr), 32'h06);
    check("rd_tx_data2", 32'(tx_data),   32'h3C);

    send(10'h0FF);
    idle(1);
    send(10'h111);
    ack_on(1, 8'h00);
    idle(1);
    check("wrap_addr_ff", 32'(last_addr), 32'hFF);
    send(10'h122);
    ack_on(1, 8'h00);
    idle(1);
    check("wrap_addr_00", 32'(last_addr), 32'h00);

    clear_mon();
    send(10'h155);
    wait_idle(40);
    idle(1);
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_err_cycles", 32'(err_cycles), 32'd1);
    check("to_busy",       32'(busy),       32'd0);
    clear_mon();
    send(10'h166);
    ack_on(1, 8'h00);
    idle(1);
    check("to_no_inc_addr", 32'(last_addr),  32'h01);
    check("after_to_req",   32'(req_cycles), 32'd1);

    clear_mon();
    send(10'h177);
    ack_on(16, 8'h00);
    idle(1);
    check("ack_last_req", 32'(req_cycles), 32'd16);
    check("ack_last_err", 32'(err_cycles), 32'd0);

    clear_mon();
    send(10'h188);
    idle(1);
    send(10'h040);
    ack_on(1, 8'h00);
    idle(2);
    check("drop_err",  32'(err_cycles), 32'd1);
    check("drop_req",  32'(req_cycles), 32'd3);
    send(10'h199);
    ack_on(1, 8'h00);
    idle(1);
    check("drop_addr", 32'(last_addr), 32'h04);

    clear_mon();
    send(10'h1AA);
    idle(15);
    rx_data  = 10'h040;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    idle(2);
    check("coinc_err",  32'(err_cycles), 32'd1);
    check("coinc_req",  32'(req_cycles), 32'd16);
    check("coinc_busy", 32'(busy),       32'd0);

    clear_mon();
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    step();
    mem_ack = 1'b0;
    idle(2);
    check("idle_ack_tx_data", 32'(tx_data),    32'h3C);
    check("idle_ack_req",     32'(req_cycles), 32'd0);

    send(10'h300);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrd_rst_req",      32'(mem_req),  32'd0);
    check("midrd_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrd_rst_busy",     32'(busy),     32'd0);
    check("midrd_rst_addr",     32'(mem_addr), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    clear_mon();
    send(10'h300);
    idle(2);
    check("rst_clears_rd_vld_err", 32'(err_cycles), 32'd1);
    check("rst_clears_rd_vld_req", 32'(req_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
